// File: rtl/stream_xors_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : stream_xors_pkg
//  Brief    : Shared types and helpers for the XOR-stream deserializer.
//  Revision : 1.0 - initial release
// ============================================================================
package stream_xors_pkg;

    localparam int XOR_BLK_W = 16;
    localparam int XOR_BLK_H = 16;

    typedef logic [XOR_BLK_H-1:0][XOR_BLK_W-1:0] xor_blk_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DROP = 2'd2
    } wr_state_t;

    function automatic int bits_per_blk(input int w, input int h, input int d);
        return (w / d) * (h / d);
    endfunction

endpackage
`default_nettype wire

// File: rtl/stream_blk_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : stream_blk_buffer
//  Brief    : One block buffer: DxD replicated bit write, sideband latch, full flag.
//  Revision : 1.0 - initial release
// ============================================================================
module stream_blk_buffer
    import stream_xors_pkg::*;
#(
    parameter int BLK_W           = 16,
    parameter int BLK_H           = 16,
    parameter int DECIMATE_FACTOR = 2,
    parameter int CONF_W          = 8,
    parameter int DISP_W          = 8,
    parameter int IDX_W           = 6
) (
    input  logic                         clk50,
    input  logic                         reset,
    input  logic                         wr_en,
    input  logic                         wr_bit,
    input  logic [IDX_W-1:0]             wr_idx,
    input  logic                         side_en,
    input  logic [CONF_W-1:0]            conf_in,
    input  logic [DISP_W-1:0]            disp_in,
    input  logic                         set_full,
    input  logic                         clr_full,
    output logic [BLK_H-1:0][BLK_W-1:0]  blk,
    output logic [CONF_W-1:0]            conf,
    output logic [DISP_W-1:0]            disp,
    output logic                         full
);

    localparam int COLS = BLK_W / DECIMATE_FACTOR;

    int sel_row;
    int sel_col;

    always_comb begin
        sel_row = int'(wr_idx) / COLS;
        sel_col = int'(wr_idx) % COLS;
    end

    always_ff @(posedge clk50) begin
        if (!reset) begin
            blk  <= '0;
            conf <= '0;
            disp <= '0;
            full <= 1'b0;
        end else begin
            // Each decimated bit fills the DxD square it stands for.
            if (wr_en) begin
                for (int y = 0; y < BLK_H; y++) begin
                    for (int x = 0; x < BLK_W; x++) begin
                        if ((y / DECIMATE_FACTOR) == sel_row &&
                            (x / DECIMATE_FACTOR) == sel_col) begin
                            blk[y][x] <= wr_bit;
                        end
                    end
                end
            end
            if (side_en) begin
                conf <= conf_in;
                disp <= disp_in;
            end
            if (set_full) begin
                full <= 1'b1;
            end else if (clr_full) begin
                full <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/stream_to_xors.sv
`default_nettype none
// ============================================================================
//  Module   : stream_to_xors
//  Brief    : Rebuilds XOR blocks from a 1-bit decimated stream into a ping-pong buffer.
//  Revision : 1.0 - initial release
// ============================================================================
module stream_to_xors
    import stream_xors_pkg::*;
#(
    parameter int BLK_W           = XOR_BLK_W,
    parameter int BLK_H           = XOR_BLK_H,
    parameter int DECIMATE_FACTOR = 2,
    parameter int CONF_W          = 8,
    parameter int DISP_W          = 8
) (
    input  logic                         clk50,
    input  logic                         reset,
    input  logic                         pix_stream_data,
    input  logic                         pix_stream_valid,
    input  logic [CONF_W-1:0]            conf_in,
    input  logic [DISP_W-1:0]            disp_in,
    output logic                         stream_almost_full,
    output logic [BLK_H-1:0][BLK_W-1:0]  blk_out,
    output logic [CONF_W-1:0]            conf_out,
    output logic [DISP_W-1:0]            disp_out,
    output logic                         blk_valid,
    input  logic                         blk_ready,
    output logic                         overflow,
    output logic [15:0]                  blk_count
);

    localparam int N     = bits_per_blk(BLK_W, BLK_H, DECIMATE_FACTOR);
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    wr_state_t                        state;
    logic [CNT_W-1:0]                 bit_cnt;
    logic                             wr_sel;
    logic                             rd_sel;
    logic [1:0]                       full;
    logic [BLK_H-1:0][BLK_W-1:0]      buf_blk  [2];
    logic [CONF_W-1:0]                buf_conf [2];
    logic [DISP_W-1:0]                buf_disp [2];

    logic accept_first;
    logic store;
    logic complete;
    logic handshake;

    // The full check happens only at block start, so a block never lands on a busy buffer.
    assign accept_first = pix_stream_valid && (state == IDLE) && !full[wr_sel];
    assign store        = accept_first || (pix_stream_valid && (state == FILL));
    assign complete     = pix_stream_valid && (state == FILL) && (bit_cnt == LAST);
    assign handshake    = blk_valid && blk_ready;

    always_ff @(posedge clk50) begin
        if (!reset) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            wr_sel   <= 1'b0;
            overflow <= 1'b0;
        end else if (pix_stream_valid) begin
            case (state)
                IDLE: begin
                    bit_cnt <= CNT_W'(1);
                    if (!full[wr_sel]) begin
                        state <= FILL;
                    end else begin
                        overflow <= 1'b1;
                        state    <= DROP;
                    end
                end
                FILL: begin
                    if (bit_cnt == LAST) begin
                        bit_cnt <= '0;
                        wr_sel  <= ~wr_sel;
                        state   <= IDLE;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                DROP: begin
                    if (bit_cnt == LAST) begin
                        bit_cnt <= '0;
                        state   <= IDLE;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                default: begin
                    bit_cnt <= '0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk50) begin
        if (!reset) begin
            rd_sel    <= 1'b0;
            blk_count <= '0;
        end else if (handshake) begin
            rd_sel    <= ~rd_sel;
            blk_count <= blk_count + 16'd1;
        end
    end

    for (genvar i = 0; i < 2; i++) begin : g_buf
        stream_blk_buffer #(
            .BLK_W           (BLK_W),
            .BLK_H           (BLK_H),
            .DECIMATE_FACTOR (DECIMATE_FACTOR),
            .CONF_W          (CONF_W),
            .DISP_W          (DISP_W),
            .IDX_W           (CNT_W)
        ) u_buf (
            .clk50    (clk50),
            .reset    (reset),
            .wr_en    (store && (wr_sel == 1'(i))),
            .wr_bit   (pix_stream_data),
            .wr_idx   (bit_cnt),
            .side_en  (accept_first && (wr_sel == 1'(i))),
            .conf_in  (conf_in),
            .disp_in  (disp_in),
            .set_full (complete && (wr_sel == 1'(i))),
            .clr_full (handshake && (rd_sel == 1'(i))),
            .blk      (buf_blk[i]),
            .conf     (buf_conf[i]),
            .disp     (buf_disp[i]),
            .full     (full[i])
        );
    end

    assign blk_valid          = full[rd_sel];
    assign blk_out            = buf_blk[rd_sel];
    assign conf_out           = buf_conf[rd_sel];
    assign disp_out           = buf_disp[rd_sel];
    assign stream_almost_full = full[0] | full[1];

endmodule
`default_nettype wire

// File: tb/tb_stream_to_xors.sv
`default_nettype none
// ============================================================================
//  Module   : tb_stream_to_xors
//  Brief    : Directed self-checking bench for stream_to_xors (D=1 and D=2 instances).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_stream_to_xors;
    import stream_xors_pkg::*;

    logic clk50 = 1'b0;
    always #10 clk50 = ~clk50;

    logic reset;

    logic       data1, valid1, ready1, almost1, bvalid1, ovf1;
    logic [7:0] conf1, disp1, confo1, dispo1;
    logic [15:0] cnt1;
    xor_blk_t   blk1;

    logic       data2, valid2, ready2, almost2, bvalid2, ovf2;
    logic [7:0] conf2, disp2, confo2, dispo2;
    logic [15:0] cnt2;
    xor_blk_t   blk2;

    stream_to_xors #(.BLK_W(16), .BLK_H(16), .DECIMATE_FACTOR(1), .CONF_W(8), .DISP_W(8)) dut1 (
        .clk50(clk50), .reset(reset),
        .pix_stream_data(data1), .pix_stream_valid(valid1),
        .conf_in(conf1), .disp_in(disp1),
        .stream_almost_full(almost1), .blk_out(blk1),
        .conf_out(confo1), .disp_out(dispo1),
        .blk_valid(bvalid1), .blk_ready(ready1),
        .overflow(ovf1), .blk_count(cnt1)
    );

    stream_to_xors #(.BLK_W(16), .BLK_H(16), .DECIMATE_FACTOR(2), .CONF_W(8), .DISP_W(8)) dut2 (
        .clk50(clk50), .reset(reset),
        .pix_stream_data(data2), .pix_stream_valid(valid2),
        .conf_in(conf2), .disp_in(disp2),
        .stream_almost_full(almost2), .blk_out(blk2),
        .conf_out(confo2), .disp_out(dispo2),
        .blk_valid(bvalid2), .blk_ready(ready2),
        .overflow(ovf2), .blk_count(cnt2)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk50);
        #1;
    endtask

    task automatic do_reset();
        valid1 = 1'b0;
        valid2 = 1'b0;
        reset  = 1'b0;
        tick();
        tick();
        reset  = 1'b1;
    endtask

    // Sideband is scrambled after the first bit so only the first-bit sample can match.
    task automatic send_block(input logic [63:0] bits, input logic [7:0] c, input logic [7:0] d,
                              input bit gaps, input int nbits);
        for (int k = 0; k < nbits; k++) begin
            if (gaps && ($urandom_range(0, 1) == 1)) begin
                valid2 = 1'b0;
                data2  = ~bits[k];
                conf2  = 8'hFF;
                disp2  = 8'hFF;
                repeat ($urandom_range(1, 3)) tick();
            end
            valid2 = 1'b1;
            data2  = bits[k];
            conf2  = c;
            disp2  = d;
            tick();
            conf2  = ~c;
            disp2  = ~d;
        end
        valid2 = 1'b0;
    endtask

    localparam logic [63:0] PAT_A    = 64'h0000_0000_0000_0001;
    localparam logic [63:0] PAT_B    = 64'h8000_0000_0000_0000;
    localparam logic [63:0] PAT_ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    xor_blk_t exp_a, exp_b, exp_ones, exp_alt;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        exp_a     = '0;
        exp_a[0]  = 16'h0003;
        exp_a[1]  = 16'h0003;
        exp_b     = '0;
        exp_b[14] = 16'hC000;
        exp_b[15] = 16'hC000;
        exp_ones  = {16{16'hFFFF}};
        exp_alt   = {16{16'hAAAA}};

        data1 = 1'b0; conf1 = '0; disp1 = '0; ready1 = 1'b1;
        data2 = 1'b0; conf2 = '0; disp2 = '0; ready2 = 1'b1;
        do_reset();

        check("rst_valid",  bvalid2, 1'b0);
        check("rst_almost", almost2, 1'b0);
        check("rst_blk",    blk2,    '0);
        check("rst_conf",   confo2,  8'h00);
        check("rst_ovf",    ovf2,    1'b0);
        check("rst_count",  cnt2,    16'd0);

        // D=1 alternating columns
        for (int k = 0; k < 256; k++) begin
            valid1 = 1'b1;
            data1  = k[0];
            conf1  = (k == 0) ? 8'h5A : 8'h00;
            disp1  = (k == 0) ? 8'h11 : 8'h00;
            tick();
            if (k == 254) check("s1_valid_early", bvalid1, 1'b0);
        end
        valid1 = 1'b0;
        check("s1_valid", bvalid1, 1'b1);
        check("s1_blk",   blk1,    exp_alt);
        check("s1_conf",  confo1,  8'h5A);
        check("s1_disp",  dispo1,  8'h11);
        tick();
        check("s1_count", cnt1,    16'd1);
        check("s1_drain", bvalid1, 1'b0);

        // D=2 corner bits, continuous
        send_block(PAT_A, 8'h21, 8'h43, 1'b0, 64);
        check("s2a_valid", bvalid2, 1'b1);
        check("s2a_blk",   blk2,    exp_a);
        check("s2a_conf",  confo2,  8'h21);
        check("s2a_disp",  dispo2,  8'h43);
        send_block(PAT_B, 8'h65, 8'h87, 1'b0, 64);
        check("s2b_blk",   blk2,    exp_b);
        check("s2b_conf",  confo2,  8'h65);
        check("s2b_disp",  dispo2,  8'h87);
        check("s2b_count", cnt2,    16'd1);
        tick();
        check("s2_count",  cnt2,    16'd2);

        // Backpressure: two stored, third dropped
        do_reset();
        ready2 = 1'b0;
        send_block(PAT_A, 8'h01, 8'h10, 1'b0, 64);
        check("s3_almost1", almost2, 1'b1);
        check("s3_valid1",  bvalid2, 1'b1);
        send_block(PAT_B, 8'h02, 8'h20, 1'b0, 64);
        check("s3_ovf_b",   ovf2,    1'b0);
        send_block(PAT_ONES, 8'h03, 8'h30, 1'b0, 64);
        check("s3_ovf_c",   ovf2,    1'b1);
        check("s3_hold_blk",  blk2,   exp_a);
        check("s3_hold_conf", confo2, 8'h01);
        ready2 = 1'b1;
        tick();
        check("s3_second_blk",  blk2,   exp_b);
        check("s3_second_conf", confo2, 8'h02);
        check("s3_count1",      cnt2,   16'd1);
        tick();
        check("s3_empty",   bvalid2, 1'b0);
        check("s3_almost0", almost2, 1'b0);
        check("s3_count2",  cnt2,    16'd2);
        send_block(PAT_ONES, 8'h04, 8'h40, 1'b0, 64);
        check("s3_after_drop_blk",  blk2,   exp_ones);
        check("s3_after_drop_conf", confo2, 8'h04);
        check("s3_ovf_sticky",      ovf2,   1'b1);

        // Gappy stream must match the continuous result
        do_reset();
        send_block(PAT_A, 8'h21, 8'h43, 1'b1, 64);
        check("s4a_blk",  blk2,   exp_a);
        check("s4a_conf", confo2, 8'h21);
        check("s4a_disp", dispo2, 8'h43);
        send_block(PAT_B, 8'h65, 8'h87, 1'b1, 64);
        check("s4b_blk",  blk2,   exp_b);
        check("s4b_conf", confo2, 8'h65);
        check("s4b_disp", dispo2, 8'h87);

        // Reset mid-block
        send_block(PAT_ONES, 8'hEE, 8'hEE, 1'b0, 30);
        check("s5_count_pre", cnt2, 16'd2);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("s5_valid",  bvalid2, 1'b0);
        check("s5_almost", almost2, 1'b0);
        check("s5_blk",    blk2,    '0);
        check("s5_conf",   confo2,  8'h00);
        check("s5_disp",   dispo2,  8'h00);
        check("s5_count",  cnt2,    16'd0);
        check("s5_ovf",    ovf2,    1'b0);
        ready2 = 1'b0;
        send_block(PAT_ONES, 8'h3C, 8'hC3, 1'b0, 63);
        check("s5_valid_63", bvalid2, 1'b0);
        send_block(PAT_ONES, 8'h3C, 8'hC3, 1'b0, 1);
        check("s5_valid_64", bvalid2, 1'b1);
        check("s5_blk_new",  blk2,    exp_ones);
        check("s5_conf_new", confo2,  8'h3C);
        check("s5_disp_new", dispo2,  8'hC3);

        // Completion and handshake in the same cycle
        do_reset();
        ready2 = 1'b0;
        send_block(PAT_A, 8'h0A, 8'hA0, 1'b0, 64);
        send_block(PAT_B, 8'h0B, 8'hB0, 1'b0, 63);
        check("s6_pre_blk", blk2, exp_a);
        valid2 = 1'b1;
        data2  = 1'b1;
        conf2  = 8'h00;
        ready2 = 1'b1;
        tick();
        valid2 = 1'b0;
        check("s6_valid",  bvalid2, 1'b1);
        check("s6_blk",    blk2,    exp_b);
        check("s6_conf",   confo2,  8'h0B);
        check("s6_count",  cnt2,    16'd1);
        check("s6_ovf",    ovf2,    1'b0);
        tick();
        check("s6_count2", cnt2,    16'd2);
        check("s6_empty",  bvalid2, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
